// File: rtl/pool_out_buffer.sv
// Frame buffer after the pooling stage: collects DEPTH addressed samples, then drains them in index order.
// Optional build macro POOL_BUF_RELU_EN clamps negative samples to zero when they are written.
module pool_out_buffer #(
  parameter int DEPTH  = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pool_data,
  input  logic              pool_valid,
  input  logic [15:0]       pool_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [7:0]        frame_cnt,
  output logic              err_addr,
  output logic              err_ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FILL, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  mask_reg, mask_next, mask_set;
  logic [5:0]        rd_idx_reg, rd_idx_next;
  logic [7:0]        frame_cnt_reg;
  logic              err_addr_reg, err_ovf_reg;

  logic              addr_ok, wr_en, rd_last, handshake;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign addr_ok   = pool_addr < 16'(DEPTH);
  assign wr_idx    = pool_addr[AW-1:0];
  assign wr_en     = (state_reg == FILL) && pool_valid && addr_ok;
  assign rd_last   = rd_idx_reg == 6'(DEPTH - 1);
  assign handshake = (state_reg == DRAIN) && out_ready;

`ifdef POOL_BUF_RELU_EN
  assign wr_data = pool_data[DATA_W-1] ? '0 : pool_data;
`else
  assign wr_data = pool_data;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mask_set
      assign mask_set[gi] = wr_en && (wr_idx == AW'(gi));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    mask_next   = mask_reg;
    rd_idx_next = rd_idx_reg;
    case (state_reg)
      FILL: begin
        // A repeated address only rewrites data; the OR keeps the count of distinct entries honest.
        mask_next = mask_reg | mask_set;
        if (&mask_next) begin
          state_next  = DRAIN;
          rd_idx_next = '0;
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (rd_last) begin
            state_next  = FILL;
            mask_next   = '0;
            rd_idx_next = '0;
          end else begin
            rd_idx_next = rd_idx_reg + 6'd1;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FILL;
      mask_reg      <= '0;
      rd_idx_reg    <= '0;
      frame_cnt_reg <= '0;
      err_addr_reg  <= 1'b0;
      err_ovf_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mask_reg   <= mask_next;
      rd_idx_reg <= rd_idx_next;
      if (handshake && rd_last) frame_cnt_reg <= frame_cnt_reg + 8'd1;
      if (pool_valid && !addr_ok) err_addr_reg <= 1'b1;
      if (pool_valid && (state_reg == DRAIN)) err_ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Outputs come from registered state and a registered read index, never from out_ready.
  assign out_valid = (state_reg == DRAIN);
  assign out_data  = (state_reg == DRAIN) ? mem[rd_idx_reg[AW-1:0]] : '0;
  assign out_last  = (state_reg == DRAIN) && rd_last;
  assign frame_cnt = frame_cnt_reg;
  assign err_addr  = err_addr_reg;
  assign err_ovf   = err_ovf_reg;

endmodule
